// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART blocks: default clock and line rates,
//   the bit-period computation and the transmit FSM state encoding.
//   No ports.

package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Last value of the baud counter; one bit lasts baud_end()+1 clocks.
  function automatic int baud_end(input int clk_freq, input int baud);
    return clk_freq / baud - 1;
  endfunction

  // Counter width able to hold 0..max_val (never narrower than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO. dout always presents the head entry, so a
//   pop consumes the value visible in the same cycle.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointers and count only)
//   push   in   write din; ignored while full
//   pop    in   drop head entry; ignored while empty
//   din    in   write data
//   dout   out  head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  registered occupancy, 0..DEPTH

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  // Flags come from the registered count only, so a pop in the same cycle
  // never opens room for a push that arrives while full.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf
//   Buffered 8N1 UART transmitter: bytes strobed in with tx_trig are queued
//   in a sync_fifo and sent LSB first, one frame at a time.
// Ports:
//   sclk      in   system clock, rising edge
//   s_rst_n   in   asynchronous active-low reset
//   tx_trig   in   one-cycle write strobe
//   tx_data   in   byte to enqueue
//   rs232_tx  out  serial line, idle high, registered
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds no bytes
//   busy      out  a frame is in progress
//   overflow  out  one-cycle pulse after a write dropped because full
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high; pops the head byte into the shifter when not empty
// START | start bit (low) for one bit time
// DATA  | 8 data bits LSB first, bit_cnt selects the bit in flight
// STOP  | stop bit (high) for one bit time, then back to IDLE
//
// rs232_tx is registered from the current state, so the line lags the state
// by one clock: a write at edge n pops at n+1 and drives the start bit at n+2.

module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int DEPTH    = 16
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       tx_trig,
  input  logic [7:0] tx_data,
  output logic       rs232_tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow
);

  localparam int BAUD_END = baud_end(CLK_FREQ, BAUD);
  localparam int CNT_W    = cnt_width(BAUD_END);
  localparam logic [CNT_W-1:0] BAUD_END_C = CNT_W'(BAUD_END);
  localparam int FILL_W   = $clog2(DEPTH) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              bit_done;

  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              fifo_empty;
  logic [FILL_W-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst_n (s_rst_n),
    .push  (tx_trig),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign empty    = fifo_empty;
  assign rs232_tx = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    bit_done   = (baud_cnt_q == BAUD_END_C);

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;   // wraps to 0 after bit 7
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase

    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    // Same registered-count test the FIFO uses to refuse the push.
    overflow_d = tx_trig && (fifo_count == FILL_FULL);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
module tb_uart_tx_buf;

  localparam int CLK_FREQ   = 100;
  localparam int BAUD       = 10;
  localparam int DEPTH      = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;   // 10
  localparam int FRAME_CLKS = 10 * BIT_CLKS;     // 100
  localparam int IDLE_LIMIT = 4000;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b1;
  logic       tx_trig = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rs232_tx, full, empty, busy, overflow;

  uart_tx_buf #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .tx_trig  (tx_trig),
    .tx_data  (tx_data),
    .rs232_tx (rs232_tx),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 sclk = ~sclk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Queue of buffered bytes; the transmitter takes the head byte whenever
  // it has been free for a whole frame plus one idle clock.
  int          edge_no = 0;
  byte unsigned mq[$];
  byte unsigned line_q[$];
  int          pop_edge = -1;
  logic [7:0]  cur_byte = 8'h00;
  logic        exp_ovf = 1'b0;

  always @(posedge sclk or negedge s_rst_n) begin : model
    int sz;
    bit idle_now;
    if (!s_rst_n) begin
      mq.delete();
      line_q.delete();
      pop_edge = -1;
      exp_ovf  = 1'b0;
    end else begin
      edge_no++;
      sz       = mq.size();
      idle_now = (pop_edge < 0) || (edge_no >= pop_edge + FRAME_CLKS + 1);
      exp_ovf  = tx_trig && (sz == DEPTH);
      if (tx_trig && sz < DEPTH) begin
        mq.push_back(tx_data);
        line_q.push_back(tx_data);
      end
      if (idle_now && sz > 0) begin
        cur_byte = mq.pop_front();
        pop_edge = edge_no;
      end
    end
  end

  function automatic logic exp_tx();
    int d;
    if (pop_edge < 0) return 1'b1;
    d = edge_no - pop_edge - 1;
    if (d < 0 || d >= FRAME_CLKS) return 1'b1;
    if (d / BIT_CLKS == 0) return 1'b0;
    if (d / BIT_CLKS == 9) return 1'b1;
    return cur_byte[d / BIT_CLKS - 1];
  endfunction

  function automatic logic exp_busy();
    int d;
    if (pop_edge < 0) return 1'b0;
    d = edge_no - pop_edge;
    return (d >= 0 && d < FRAME_CLKS);
  endfunction

  // ---------------- per-cycle checks and line decoder ----------------
  bit         chk_en = 0;
  logic       prev_tx = 1'b1;
  bit         rx_act = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] last_rx = 8'h00;
  int         fall_edges[$];

  task automatic per_cycle();
    logic [8:0] exp_b;
    if (chk_en) begin
      check("rs232_tx", rs232_tx, exp_tx());
      check("busy", busy, exp_busy());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, exp_ovf);
      check("count", dut.u_fifo.count, mq.size());
    end
    if (!s_rst_n) begin
      rx_act  = 0;
      prev_tx = 1'b1;
    end else begin
      if (!rx_act) begin
        if (prev_tx && !rs232_tx) begin
          rx_act = 1;
          rx_cnt = 0;
          fall_edges.push_back(edge_no);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 5) check("start_bit", rs232_tx, 0);
        else if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5)
          rx_byte[(rx_cnt - 15) / 10] = rs232_tx;
        else if (rx_cnt == 95) begin
          check("stop_bit", rs232_tx, 1);
          exp_b = (line_q.size() > 0) ? {1'b0, line_q.pop_front()} : 9'h100;
          check("line_byte", {1'b0, rx_byte}, exp_b);
          last_rx = rx_byte;
          rx_act  = 0;
        end
      end
      prev_tx = rs232_tx;
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    per_cycle();
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_trig = 1'b1;
    tx_data = d;
    tick();
    tx_trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(empty && !busy) && n < IDLE_LIMIT) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", n >= IDLE_LIMIT, 0);
  endtask

  // drain: wait for an idle block first; fall_ofs: expected clocks from the
  // group's first write edge to the start-bit falling edge.
  typedef struct {
    bit         drain;
    logic [7:0] data;
    int         fall_ofs;
  } vec_t;

  vec_t vecs[7];
  int   exp_falls[$];

  initial begin
    int base;
    int n;
    int nf;

    vecs[0] = '{1'b1, 8'hA5, 2};
    vecs[1] = '{1'b1, 8'h01, 2};
    vecs[2] = '{1'b0, 8'h02, 2 + FRAME_CLKS + 1};
    vecs[3] = '{1'b0, 8'h03, 2 + 2 * (FRAME_CLKS + 1)};
    vecs[4] = '{1'b1, 8'h80, 2};
    vecs[5] = '{1'b0, 8'h7E, 2 + FRAME_CLKS + 1};
    vecs[6] = '{1'b1, 8'hFF, 2};

    // Reset values
    #2 s_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_tx", rs232_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", dut.u_fifo.count, 0);
    s_rst_n = 1'b1;
    chk_en  = 1;
    repeat (3) tick();

    // Table: single frames, back-to-back groups, start-edge timing
    fall_edges.delete();
    base = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].drain) begin
        wait_idle();
        repeat (3) tick();
      end
      write_byte(vecs[i].data);
      if (vecs[i].drain) base = edge_no;
      exp_falls.push_back(base + vecs[i].fall_ofs);
    end
    wait_idle();
    check("fall_count", fall_edges.size(), exp_falls.size());
    for (int i = 0; i < exp_falls.size() && i < fall_edges.size(); i++)
      check("start_edge", fall_edges[i], exp_falls[i]);
    check("empty_after_table", empty, 1);

    // Fill during a frame, overflow on the 17th write
    repeat (3) tick();
    write_byte(8'h55);
    repeat (3) tick();
    check("busy_during_frame", busy, 1);
    for (int i = 0; i < 17; i++) begin
      tx_trig = 1'b1;
      tx_data = 8'(i);
      tick();
      if (i == 15) check("full_after_16", full, 1);
      if (i == 16) check("overflow_17th", overflow, 1);
    end
    tx_trig = 1'b0;
    tick();
    check("overflow_one_cycle", overflow, 0);

    // Write while full in the same cycle the idle FSM pops
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("frame_end_timeout", n >= 200, 0);
    check("full_at_pop", full, 1);
    write_byte(8'hEE);
    check("overflow_at_pop", overflow, 1);
    check("count_after_pop", dut.u_fifo.count, 15);
    check("full_after_pop", full, 0);
    wait_idle();
    check("line_q_after_fill", line_q.size(), 0);

    // Reset in DATA bit 3 of 0xFF with 4 bytes queued
    repeat (3) tick();
    write_byte(8'hFF);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    n = 0;
    while (!(pop_edge >= 0 && edge_no - pop_edge - 1 == 45) && n < 300) begin
      tick();
      n++;
    end
    check("bit3_timeout", n >= 300, 0);
    check("count_before_rst", dut.u_fifo.count, 4);
    s_rst_n = 1'b0;
    #1;
    check("midrst_tx", rs232_tx, 1);
    check("midrst_empty", empty, 1);
    check("midrst_busy", busy, 0);
    check("midrst_count", dut.u_fifo.count, 0);
    repeat (2) tick();
    s_rst_n = 1'b1;
    nf = fall_edges.size();
    repeat (300) tick();
    check("no_frames_after_rst", fall_edges.size(), nf);
    write_byte(8'h3C);
    wait_idle();
    repeat (3) tick();
    check("first_after_rst", last_rx, 8'h3C);
    check("frames_after_rst", fall_edges.size(), nf + 1);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 19) begin
        for (int k = 0; k < 20; k++) write_byte(8'($urandom));
      end else begin
        repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 150)) tick();
        write_byte(8'($urandom));
      end
    end
    wait_idle();
    repeat (3) tick();
    check("line_q_drained", line_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, line rate in bit/s.
REQ-003 The block SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, at least 2).
REQ-004 sclk  input  1  system clock; all logic on its rising edge.
REQ-005 s_rst_n  input  1  asynchronous active-low reset.
REQ-006 tx_trig  input  1  single-cycle write strobe; tx_data is sampled when it is high.
REQ-007 tx_data  input  8  byte to enqueue.
REQ-008 rs232_tx  output  1  serial line, 8N1, idle high; registered output.
REQ-009 full  output  1  FIFO holds DEPTH bytes.
REQ-010 empty  output  1  FIFO holds 0 bytes.
REQ-011 busy  output  1  high while a frame is on the line (state other than IDLE).
REQ-012 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-013 BAUD_END SHALL equal CLK_FREQ/BAUD - 1, using integer division (5207 at the defaults); each bit SHALL last BAUD_END+1 clocks.
REQ-014 A write with tx_trig=1 and full=0 SHALL enqueue tx_data at that edge.
REQ-015 A write with tx_trig=1 and full=1 SHALL be discarded, and overflow SHALL be high for exactly the next cycle; FIFO contents SHALL be unchanged.
REQ-016 full and empty SHALL be derived from the registered occupancy count; a pop in the same cycle SHALL NOT make a write at full succeed.
REQ-017 Simultaneous push (not full) and pop SHALL leave the count unchanged, with both operations taking effect.
REQ-018 The FIFO read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-019 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-020 IDLE with empty=0 SHALL pop the head byte into a shift register and go to START; IDLE with empty=1 SHALL stay in IDLE.
REQ-021 In START, rs232_tx SHALL be 0 for one bit time, then the FSM SHALL go to DATA.
REQ-022 In DATA, the 8 bits SHALL be sent LSB first, one bit time each, tracked by a 3-bit bit counter; after bit 7 the FSM SHALL go to STOP.
REQ-023 In STOP, rs232_tx SHALL be 1 for one bit time, then the FSM SHALL return to IDLE.
REQ-024 The baud counter SHALL reset to 0 on every state change and count 0..BAUD_END.
REQ-025 Latency: a write at edge n into an empty, idle block SHALL drive rs232_tx low at edge n+2.
REQ-026 For back-to-back frames from a non-empty FIFO, successive falling start edges SHALL be 10*(BAUD_END+1)+1 clocks apart, with exactly one IDLE cycle between frames.
REQ-027 In IDLE, rs232_tx SHALL be 1.
REQ-028 Writes during a frame SHALL NOT disturb the byte being shifted.

Reset
REQ-029 On s_rst_n=0, asynchronously: rs232_tx=1, state=IDLE, busy=0, empty=1, full=0, overflow=0, count/pointers/baud counter/bit counter=0.
REQ-030 Reset mid-frame SHALL abort the frame, leave the line high, and discard all queued bytes.
REQ-031 After reset is released, the first byte transmitted SHALL be the first byte written after the release.

Structure
REQ-032 The shared package uart_pkg SHALL hold CLK_FREQ and BAUD defaults, the BAUD_END computation, and the FSM state encodings; uart_rx and uart_tx SHALL use the same package.
REQ-033 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width 8 and DEPTH, with ports push, pop, din, dout, full, empty and count.
REQ-034 uart_tx_buf SHALL contain only the FSM, the counters and the shift register, plus the sync_fifo instance.

Verification (benches run with CLK_FREQ=100, BAUD=10, so BAUD_END=9)
REQ-035 Write 0xA5 once -> rs232_tx low at write+2; line bits 1,0,1,0,0,1,0,1 with 10 clocks each; then high for 10 clocks; busy falls; empty=1.
REQ-036 Write 0x01, 0x02, 0x03 on consecutive cycles -> three frames in order; start edges 101 clocks apart; empty=1 after the third stop bit.
REQ-037 While the first frame is sending, write 17 bytes 0x00..0x10 -> full=1 after 16 bytes; the 17th write raises one overflow pulse and is lost; the line carries 16 bytes in order.
REQ-038 Assert s_rst_n=0 during DATA bit 3 of 0xFF with 4 bytes queued -> rs232_tx=1 immediately; empty=1; no further frames after release until a new write.
REQ-039 Hold full (16 queued) and write in the same cycle as an IDLE pop -> the write is dropped, overflow pulses, and the count reads 15 on the next cycle.
